// File: rtl/gate_truth_checker_if.sv
// Control/status and gate-side signals of the gate truth-table checker.
// The host/bench drives start, gate_sel and the gate output y; the checker drives the rest.
interface gate_truth_checker_if;
  logic       start;
  logic [2:0] gate_sel;
  logic       y;
  logic       a;
  logic       b;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] err_count;
  logic [3:0] fail_mask;
  logic [1:0] vec_idx;

  modport master (
    output start, gate_sel, y,
    input  a, b, busy, done, pass, err_count, fail_mask, vec_idx
  );

  modport slave (
    input  start, gate_sel, y,
    output a, b, busy, done, pass, err_count, fail_mask, vec_idx
  );
endinterface

// File: rtl/gate_truth_checker.sv
// Drives a 2-input gate through 00/01/10/11, samples y after a settle delay,
// and reports per-vector mismatches, an error count and a pass verdict.
module gate_truth_checker #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  gate_truth_checker_if.slave  bus
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] SAMPLE = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  logic [1:0] state;
  logic [3:0] cnt;
  logic [2:0] sel_q;
  logic       a_q, b_q, pass_q;
  logic [2:0] err_q;
  logic [3:0] mask_q;
  logic [1:0] vec_q;

  logic       sel_valid;
  logic       expect_y;
  logic       mismatch;
  logic [2:0] err_nxt;

  // 110/111 are the only unused encodings
  assign sel_valid = !(bus.gate_sel[2] && bus.gate_sel[1]);

  always_comb begin
    expect_y = 1'b0;
    case (sel_q)
      3'b000:  expect_y = a_q & b_q;
      3'b001:  expect_y = a_q | b_q;
      3'b010:  expect_y = ~(a_q & b_q);
      3'b011:  expect_y = ~(a_q | b_q);
      3'b100:  expect_y = a_q ^ b_q;
      3'b101:  expect_y = ~(a_q ^ b_q);
      default: expect_y = 1'b0;
    endcase
  end

  assign mismatch = (bus.y != expect_y);
  assign err_nxt  = err_q + {2'b00, mismatch};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      sel_q  <= '0;
      a_q    <= 1'b0;
      b_q    <= 1'b0;
      pass_q <= 1'b0;
      err_q  <= '0;
      mask_q <= '0;
      vec_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          a_q <= 1'b0;
          b_q <= 1'b0;
          if (bus.start) begin
            if (sel_valid) begin
              sel_q  <= bus.gate_sel;
              err_q  <= '0;
              mask_q <= '0;
              pass_q <= 1'b0;
              vec_q  <= '0;
              cnt    <= '0;
              state  <= SETTLE;
            end else begin
              // Invalid function: report every vector as failed without running
              err_q  <= 3'd4;
              mask_q <= 4'hf;
              pass_q <= 1'b0;
              state  <= DONE;
            end
          end
        end
        SETTLE: begin
          if (cnt == SETTLE_LAST) state <= SAMPLE;
          else                    cnt   <= cnt + 4'd1;
        end
        SAMPLE: begin
          if (mismatch) begin
            mask_q[vec_q] <= 1'b1;
            err_q         <= err_nxt;
          end
          if (vec_q == 2'd3) begin
            // Verdict must include this final sample, hence err_nxt
            pass_q <= (err_nxt == 3'd0);
            state  <= DONE;
          end else begin
            vec_q        <= vec_q + 2'd1;
            {a_q, b_q}   <= vec_q + 2'd1;
            cnt          <= '0;
            state        <= SETTLE;
          end
        end
        DONE: begin
          a_q   <= 1'b0;
          b_q   <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.a         = a_q;
  assign bus.b         = b_q;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == DONE);
  assign bus.pass      = pass_q;
  assign bus.err_count = err_q;
  assign bus.fail_mask = mask_q;
  assign bus.vec_idx   = vec_q;
endmodule

// File: doc/gate_truth_checker.md
# gate_truth_checker

Self-checking stimulus/response stage for the 2-input basic logic gates. It sits directly upstream of a gate instance, driving `a`/`b` through the full truth table (00, 01, 10, 11), and directly downstream of it, sampling `y` and comparing against the expected value for the selected gate function. It reports per-vector mismatches, an error count, and a single pass/fail verdict, so gate blocks can be checked in hardware or simulation without a hand-written `$display` table.

## Interface
- `SETTLE_CYCLES`, default 2: clocks between driving a vector and sampling `y`. Legal range 1..15.
- `clk` input, 1 bit: single clock. All state updates on the rising edge.
- `rst_n` input, 1 bit: reset, asynchronous and active-low.
- `start` input, 1 bit: begin a run. Sampled only in IDLE.
- `gate_sel` input, 3 bits: expected function. 000 AND, 001 OR, 010 NAND, 011 NOR, 100 XOR, 101 XNOR. 110 and 111 are invalid. Latched when `start` is accepted.
- `y` input, 1 bit: output of the gate under test.
- `a` output, 1 bit: gate input A, registered.
- `b` output, 1 bit: gate input B, registered.
- `busy` output, 1 bit: high from start acceptance until the DONE cycle, inclusive.
- `done` output, 1 bit: single-cycle pulse at end of run.
- `pass` output, 1 bit: verdict, valid from `done` until the next accepted `start`.
- `err_count` output, 3 bits: number of mismatching vectors (0..4).
- `fail_mask` output, 4 bits: bit i set if vector i mismatched.
- `vec_idx` output, 2 bits: index of the vector currently driven.

## Operation
- Vector mapping: `a = vec_idx[1]`, `b = vec_idx[0]`. Index 0 is 00, 1 is 01, 2 is 10, 3 is 11.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE
  - `busy=0`, `a=b=0`.
  - On `start=1` with a valid `gate_sel`: latch `gate_sel`, clear `err_count`, `fail_mask` and `pass`, set `vec_idx=0`, drive vector 0, clear the settle counter, go to SETTLE.
  - On `start=1` with an invalid `gate_sel`: set `fail_mask=1111`, `err_count=4`, `pass=0`, go directly to DONE.
- SETTLE: hold `a`/`b` for exactly `SETTLE_CYCLES` clocks, then go to SAMPLE.
- SAMPLE (one cycle)
  - Compare `y` against expected(latched `gate_sel`, `a`, `b`).
  - On mismatch: set `fail_mask[vec_idx]` and increment `err_count`.
  - If `vec_idx==3`: go to DONE.
  - Otherwise: increment `vec_idx`, drive the next vector, clear the settle counter, go to SETTLE.
- DONE (one cycle)
  - `done=1`, `busy=1`.
  - `pass` is set to `err_count==0` after the final update.
  - Then go to IDLE; `a`/`b` return to 0.
- Results hold: `err_count`, `fail_mask`, `vec_idx` (3 after a valid run) and `pass` hold in IDLE until the next accepted `start`.
- `start` while busy is ignored; no restart and no effect on results.
- `start` held high continuously: a new run begins on the first IDLE cycle after DONE.
- `y` is compared as a 2-state value; the bench must drive known levels.

## Timing
- Reset values: `a=0`, `b=0`, `busy=0`, `done=0`, `pass=0`, `err_count=0`, `fail_mask=0`, `vec_idx=0`, state IDLE.
- Reset mid-run aborts asynchronously to these values. No partial result is retained.
- Valid run:
  - Each vector occupies `SETTLE_CYCLES+1` clocks.
  - `done` is high in the cycle beginning `4*(SETTLE_CYCLES+1)` rising edges after the edge that accepted `start`.
  - Example: 12 edges when `SETTLE_CYCLES=2`.
- Invalid `gate_sel`: `done` is high in the cycle immediately after the accepting edge.
- `y` is sampled on the edge that leaves SAMPLE, i.e. `SETTLE_CYCLES+1` edges after the vector was driven.
- `a`/`b` change only on FSM edges and never glitch: they are driven directly from flops.
- `err_count` and `fail_mask` are updated on the SAMPLE exit edge. `pass` updates on the DONE entry edge and must reflect the last sample.

## Test plan
- OR gate connected, `gate_sel=001`, `SETTLE_CYCLES=2`, pulse `start` -> `a`/`b` step 00, 01, 10, 11 every 3 clocks; `done` 12 edges after start; `pass=1`, `err_count=0`, `fail_mask=0000`.
- OR gate connected, `gate_sel=000` (AND) -> `fail_mask=0110`, `err_count=2`, `pass=0`.
- `y` tied to 0, `gate_sel=001` -> `fail_mask=1110`, `err_count=3`, `pass=0`. Repeat with a NOR model and `gate_sel=011` -> `pass=1`, with results cleared at the new start.
- `gate_sel=111`, `start` -> `done` the next cycle, `fail_mask=1111`, `err_count=4`, `pass=0`, `a=b=0` throughout.
- `start` re-pulsed while `vec_idx=2` -> run unaffected and `done` at the original time. Then `rst_n` low for 1 cycle during vector 1 of a new run -> all outputs at reset values immediately and no `done` pulse.
- `SETTLE_CYCLES=1` with a registered gate model adding 1 cycle of delay -> `pass=1`. The same model with `SETTLE_CYCLES=1` and 2 cycles of delay -> at least one mismatch, `pass=0`.
